writeback_stage: RTL and testbench

//  Final pipeline stage; drives the register file write port (rd, write enable, writeback data).

---
 rtl/writeback_stage_if.sv | 32 +++
 rtl/writeback_stage.sv | 180 ++++++++++++++++++
 tb/tb_writeback_stage.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Upstream-to-writeback instruction bus.
//   valid    : upstream presents an instruction
//   ready    : writeback stage can accept it this cycle
//   rd       : destination register
//   regwren  : instruction writes rd
//   wbsel    : writeback source (0=ALU, 1=LOAD, 2=PC+4, 3=none)
//   alu_res  : ALU result; for loads, the effective address
//   pc       : instruction PC
//   funct3   : load type (LB/LH/LW/LBU/LHU)
// master = upstream stage, slave = writeback stage.
interface writeback_stage_if #(
    parameter int DWIDTH = 32
);
    logic              valid;
    logic              ready;
    logic [4:0]        rd;
    logic              regwren;
    logic [1:0]        wbsel;
    logic [DWIDTH-1:0] alu_res;
    logic [DWIDTH-1:0] pc;
    logic [2:0]        funct3;

    modport master (
        output valid, rd, regwren, wbsel, alu_res, pc, funct3,
        input  ready
    );

    modport slave (
        input  valid, rd, regwren, wbsel, alu_res, pc, funct3,
        output ready
    );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: drives the register-file write port.
// Selects ALU result, aligned/extended load data or PC+4; stalls upstream
// while a load is waiting on the data-memory response, abandoning it after
// LOAD_TIMEOUT cycles.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   up               upstream instruction bus (slave side)
//   mem_rvalid_i     load response valid (single-cycle pulse)
//   mem_rdata_i      aligned 32-bit word from data memory
//   rd_o             register-file destination
//   regwren_o        register-file write enable, one pulse per write
//   datawb_o         register-file write data
//   retire_o         one pulse per completed instruction
//   load_err_o       sticky: misaligned/illegal load or load timeout
module writeback_stage #(
    parameter int DWIDTH       = 32,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              reset_i,
    writeback_stage_if.slave  up,
    input  logic              mem_rvalid_i,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic [4:0]        rd_o,
    output logic              regwren_o,
    output logic [DWIDTH-1:0] datawb_o,
    output logic              retire_o,
    output logic              load_err_o
);
    localparam int CW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(LOAD_TIMEOUT - 1);

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_NONE = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Load context captured at accept
    logic [4:0]        l_rd;
    logic              l_regwren;
    logic [2:0]        l_funct3;
    logic [1:0]        l_off;
    logic              capture;

    // Next-cycle output values
    logic              wr_d, ret_d, err_d;
    logic [4:0]        rd_d;
    logic [DWIDTH-1:0] data_d;

    logic              accept;
    logic              load_illegal;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DWIDTH-1:0] ld_data;

    assign up.ready = (state_q == IDLE);
    assign accept   = up.valid && up.ready;

    // Alignment / legality of the load presented on the bus
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        load_illegal = 1'b1;
        case (up.funct3)
            F3_LB, F3_LBU: load_illegal = 1'b0;
            F3_LH, F3_LHU: load_illegal = up.alu_res[0];
            F3_LW:         load_illegal = (up.alu_res[1:0] != 2'b00);
            default:       load_illegal = 1'b1;
        endcase
    end

    // Extract and extend the loaded value from the response word
    always_comb begin
        ld_byte = mem_rdata_i[{l_off, 3'b000} +: 8];
        ld_half = mem_rdata_i[{l_off[1], 4'b0000} +: 16];
        case (l_funct3)
            F3_LB:   ld_data = {{(DWIDTH-8){ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data = {{(DWIDTH-8){1'b0}}, ld_byte};
            F3_LH:   ld_data = {{(DWIDTH-16){ld_half[15]}}, ld_half};
            F3_LHU:  ld_data = {{(DWIDTH-16){1'b0}}, ld_half};
            default: ld_data = mem_rdata_i;
        endcase
    end

    // Next state and next registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        wr_d    = 1'b0;
        ret_d   = 1'b0;
        err_d   = 1'b0;
        rd_d    = up.rd;
        data_d  = up.alu_res;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (up.wbsel == WB_LOAD) begin
                        if (load_illegal) begin
                            ret_d = 1'b1;
                            err_d = 1'b1;
                        end else begin
                            state_d = WAIT_LOAD;
                            cnt_d   = '0;
                            capture = 1'b1;
                        end
                    end else begin
                        ret_d  = 1'b1;
                        wr_d   = up.regwren && (up.rd != 5'd0) && (up.wbsel != WB_NONE);
                        data_d = (up.wbsel == WB_PC4) ? up.pc + DWIDTH'(4) : up.alu_res;
                    end
                end
            end
            WAIT_LOAD: begin
                // A response on the timeout cycle still completes normally
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                    ret_d   = 1'b1;
                    wr_d    = l_regwren && (l_rd != 5'd0);
                    rd_d    = l_rd;
                    data_d  = ld_data;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    ret_d   = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_o       <= '0;
            regwren_o  <= 1'b0;
            datawb_o   <= '0;
            retire_o   <= 1'b0;
            load_err_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            regwren_o <= wr_d;
            retire_o  <= ret_d;
            // Write port data holds its last value on non-writing cycles
            if (wr_d) begin
                rd_o     <= rd_d;
                datawb_o <= data_d;
            end
            if (err_d) begin
                load_err_o <= 1'b1;
            end
        end
    end

    // NOTE: load context is pure datapath, only read in WAIT_LOAD after capture, so it has no reset.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            l_rd      <= up.rd;
            l_regwren <= up.regwren;
            l_funct3  <= up.funct3;
            l_off     <= up.alu_res[1:0];
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [4:0]  rd_o;
    logic        regwren_o;
    logic [31:0] datawb_o;
    logic        retire_o;
    logic        load_err_o;

    writeback_stage_if #(.DWIDTH(32)) up_if ();

    writeback_stage #(.DWIDTH(32), .LOAD_TIMEOUT(15)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .up           (up_if.slave),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .rd_o         (rd_o),
        .regwren_o    (regwren_o),
        .datawb_o     (datawb_o),
        .retire_o     (retire_o),
        .load_err_o   (load_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic err_model = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_illegal(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return off[0];
            3'b010:         return off != 2'b00;
            default:        return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [31:0] sb, sh;
        sb = w >> (8 * off);
        sh = w >> (off[1] ? 16 : 0);
        case (f3)
            3'b000:  return {{24{sb[7]}}, sb[7:0]};
            3'b100:  return {24'h0, sb[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // Scoreboard: every retire pops one expected completion
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (retire_o) begin
                if (q.size() == 0) begin
                    check("unexpected_retire", 32'(retire_o), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("regwren", 32'(regwren_o), 32'(e.wr));
                    if (e.wr) begin
                        check("rd", 32'(rd_o), 32'(e.rd));
                        check("datawb", datawb_o, e.data);
                    end
                    check("load_err", 32'(load_err_o), 32'(e.err));
                end
            end else if (regwren_o) begin
                check("write_without_retire", 32'(regwren_o), 32'd0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        q.delete();
        err_model = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    // Present one instruction, push its expected result, return on the negedge after accept
    task automatic issue(input logic [1:0] wbsel, input logic [4:0] rd, input logic wren,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3,
                         input logic [31:0] rdata, input logic timeout);
        exp_t e;
        logic immediate;
        int   n;
        @(negedge clk_i);
        up_if.valid   = 1'b1;
        up_if.wbsel   = wbsel;
        up_if.rd      = rd;
        up_if.regwren = wren;
        up_if.alu_res = alu;
        up_if.pc      = pc;
        up_if.funct3  = f3;
        n = 0;
        while (!up_if.ready && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!up_if.ready) check("accept_bound", 32'(up_if.ready), 32'd1);
        e.rd   = rd;
        e.data = 32'h0;
        e.wr   = 1'b0;
        immediate = 1'b1;
        if (wbsel != 2'd1) begin
            e.wr   = wren && rd != 5'd0 && wbsel != 2'd3;
            e.data = (wbsel == 2'd2) ? pc + 32'd4 : alu;
        end else if (is_illegal(f3, alu[1:0])) begin
            err_model = 1'b1;
        end else begin
            immediate = 1'b0;
            if (timeout) err_model = 1'b1;
            else begin
                e.wr   = wren && rd != 5'd0;
                e.data = extract(f3, alu[1:0], rdata);
            end
        end
        e.err = err_model;
        q.push_back(e);
        @(posedge clk_i);
        @(negedge clk_i);
        up_if.valid = 1'b0;
        if (immediate) check("retire_latency", 32'(retire_o), 32'd1);
    endtask

    // Legal load answered after 'delay' further cycles
    task automatic do_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                           input logic [31:0] rdata, input int delay);
        issue(2'd1, rd, 1'b1, addr, 32'h0, f3, rdata, 1'b0);
        for (int i = 0; i < delay; i++) begin
            check("ready_low_wait", 32'(up_if.ready), 32'd0);
            @(negedge clk_i);
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
        check("ready_low_rvalid", 32'(up_if.ready), 32'd0);
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        check("load_retire", 32'(retire_o), 32'd1);
        check("ready_after_load", 32'(up_if.ready), 32'd1);
    endtask

    initial begin
        int n;
        reset_i       = 1'b1;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = 32'h0;
        up_if.valid   = 1'b0;
        up_if.wbsel   = 2'd0;
        up_if.rd      = 5'd0;
        up_if.regwren = 1'b0;
        up_if.alu_res = 32'h0;
        up_if.pc      = 32'h0;
        up_if.funct3  = 3'd0;
        do_reset();
        check("rst_rd", 32'(rd_o), 32'd0);
        check("rst_regwren", 32'(regwren_o), 32'd0);
        check("rst_datawb", datawb_o, 32'd0);
        check("rst_retire", 32'(retire_o), 32'd0);
        check("rst_err", 32'(load_err_o), 32'd0);
        check("rst_ready", 32'(up_if.ready), 32'd1);

        // Non-load writebacks
        issue(2'd0, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 3'd0, 32'h0, 1'b0);
        issue(2'd0, 5'd0, 1'b1, 32'h0000_5678, 32'h0, 3'd0, 32'h0, 1'b0);
        issue(2'd2, 5'd1, 1'b1, 32'h0, 32'hFFFF_FFFC, 3'd0, 32'h0, 1'b0);
        issue(2'd2, 5'd7, 1'b1, 32'h0, 32'h0000_1000, 3'd0, 32'h0, 1'b0);
        issue(2'd3, 5'd9, 1'b1, 32'hAAAA_AAAA, 32'h0, 3'd0, 32'h0, 1'b0);
        check("hold_datawb", datawb_o, 32'h0000_1004);
        issue(2'd0, 5'd9, 1'b0, 32'h5555_5555, 32'h0, 3'd0, 32'h0, 1'b0);
        check("hold_rd", 32'(rd_o), 32'd7);

        // Legal loads
        do_load(3'b000, 5'd3,  32'h0000_1002, 32'h0080_0000, 3);
        do_load(3'b101, 5'd4,  32'h0000_2002, 32'hBEEF_1234, 1);
        do_load(3'b100, 5'd6,  32'h0000_3003, 32'h8A00_0000, 0);
        do_load(3'b001, 5'd8,  32'h0000_4000, 32'h0000_8001, 2);
        do_load(3'b010, 5'd10, 32'h0000_5000, 32'h1234_5678, 5);
        do_load(3'b000, 5'd0,  32'h0000_6001, 32'h0000_7F00, 1);
        do_load(3'b000, 5'd11, 32'h0000_6001, 32'h0000_7F00, 1);

        // Misaligned / illegal loads: error, no write, no stall
        issue(2'd1, 5'd12, 1'b1, 32'h0000_7001, 32'h0, 3'b010, 32'h0, 1'b0);
        check("err_ready", 32'(up_if.ready), 32'd1);
        do_reset();
        issue(2'd1, 5'd12, 1'b1, 32'h0000_7003, 32'h0, 3'b001, 32'h0, 1'b0);
        do_reset();
        issue(2'd1, 5'd12, 1'b1, 32'h0000_7000, 32'h0, 3'b011, 32'h0, 1'b0);
        do_reset();

        // Timeout after 15 waiting cycles, then a late response is ignored
        issue(2'd1, 5'd13, 1'b1, 32'h0000_8000, 32'h0, 3'b010, 32'h0, 1'b1);
        n = 0;
        while (!up_if.ready && n < 40) begin
            n++;
            @(negedge clk_i);
        end
        check("timeout_cycles", 32'(n), 32'd15);
        check("timeout_retire", 32'(retire_o), 32'd1);
        check("timeout_err", 32'(load_err_o), 32'd1);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_F00D;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        check("late_rvalid_wr", 32'(regwren_o), 32'd0);
        check("late_rvalid_retire", 32'(retire_o), 32'd0);
        do_reset();

        // Response on the final waiting cycle completes normally
        do_load(3'b010, 5'd14, 32'h0000_9000, 32'h0BAD_CAFE, 14);
        check("edge_no_err", 32'(load_err_o), 32'd0);

        // Reset while a load is outstanding
        issue(2'd1, 5'd15, 1'b1, 32'h0000_A000, 32'h0, 3'b010, 32'h0, 1'b0);
        @(negedge clk_i);
        do_reset();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        check("rst6_regwren", 32'(regwren_o), 32'd0);
        check("rst6_retire", 32'(retire_o), 32'd0);
        check("rst6_datawb", datawb_o, 32'd0);
        check("rst6_rd", 32'(rd_o), 32'd0);
        check("rst6_err", 32'(load_err_o), 32'd0);
        check("rst6_ready", 32'(up_if.ready), 32'd1);

        repeat (3) @(negedge clk_i);
        check("sb_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
